// File: rtl/sata_cmd_issue.sv
// Host-side SATA command issuer: sends a Register H2D FIS and waits for the matching D2H status FIS.
// Optional response timeout is enabled by defining SATACMD_TIMEOUT_EN.
`timescale 1ns/1ps
module sata_cmd_issue #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_tx_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [7:0]  i_command,
  input  logic [15:0] i_features,
  input  logic [47:0] i_lba,
  input  logic [15:0] i_count,
  input  logic [7:0]  i_device,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        s_abort,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_status,
  output logic [7:0]  o_error,
  output logic        o_err,
  output logic        o_timeout
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, HDR, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  cmd_q, cmd_d, dev_q, dev_d;
  logic [15:0] feat_q, feat_d, cnt_q, cnt_d;
  logic [47:0] lba_q, lba_d;
  logic        skip_q, skip_d;
  logic [7:0]  sh_status_q, sh_status_d, sh_error_q, sh_error_d;
  logic [7:0]  status_q, status_d, error_q, error_d;
  logic        err_q, err_d, tmo_q, tmo_d;

  logic       hdr_beat, end_beat, fin_beat, tmo_hit;
  logic [7:0] eval_status, eval_error;
  logic       unused_ok;

  assign unused_ok = ^{s_data[23:16], TIMEOUT_CYCLES};

  // A header that also carries s_last is evaluated straight from the bus.
  assign hdr_beat    = s_valid && !skip_q && (s_data[31:24] == 8'h34);
  assign eval_status = (state_q == WAIT) ? s_data[15:8] : sh_status_q;
  assign eval_error  = (state_q == WAIT) ? s_data[7:0]  : sh_error_q;
  assign end_beat    = ((state_q == WAIT) && hdr_beat && s_last) ||
                       ((state_q == HDR) && s_valid && s_last);
  assign fin_beat    = end_beat && (s_abort || !eval_status[7]);

`ifdef SATACMD_TIMEOUT_EN
  logic [31:0] tcnt_q, tcnt_d;
  assign tmo_hit = ((state_q == WAIT) || (state_q == HDR)) &&
                   (tcnt_q == 32'(TIMEOUT_CYCLES - 1));
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == SEND) tcnt_d = '0;
    else if ((state_q == WAIT) || (state_q == HDR)) tcnt_d = tcnt_q + 32'd1;
  end
  always_ff @(posedge i_tx_clk) begin
    if (i_reset) tcnt_q <= '0;
    else         tcnt_q <= tcnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_tx_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_cmd_valid) state_d = SEND;
      SEND: if (m_ready && (idx_q == 3'd4)) state_d = WAIT;
      WAIT: if (hdr_beat) state_d = s_last ? (fin_beat ? DONE : WAIT) : HDR;
      HDR:  if (s_valid && s_last) state_d = fin_beat ? DONE : WAIT;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_hit && !fin_beat) state_d = DONE;
  end

  always_comb begin
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    feat_d      = feat_q;
    lba_d       = lba_q;
    cnt_d       = cnt_q;
    dev_d       = dev_q;
    skip_d      = 1'b0;
    sh_status_d = sh_status_q;
    sh_error_d  = sh_error_q;
    status_d    = status_q;
    error_d     = error_q;
    err_d       = err_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE: begin
        idx_d = 3'd0;
        if (i_cmd_valid) begin
          cmd_d  = i_command;
          feat_d = i_features;
          lba_d  = i_lba;
          cnt_d  = i_count;
          dev_d  = i_device;
        end
      end
      SEND: if (m_ready) idx_d = idx_q + 3'd1;
      WAIT: begin
        // Non-header FIS: swallow every word up to its s_last.
        if (skip_q) skip_d = !(s_valid && s_last);
        else if (s_valid && (s_data[31:24] != 8'h34)) skip_d = !s_last;
        if (hdr_beat) begin
          sh_status_d = s_data[15:8];
          sh_error_d  = s_data[7:0];
        end
      end
      default: ;
    endcase
    if (fin_beat) begin
      status_d = eval_status;
      error_d  = eval_error;
      err_d    = s_abort || eval_status[0];
      tmo_d    = 1'b0;
    end else if (tmo_hit) begin
      status_d = 8'hFF;
      error_d  = 8'h00;
      err_d    = 1'b1;
      tmo_d    = 1'b1;
    end
  end

  always_ff @(posedge i_tx_clk) begin
    if (i_reset) begin
      idx_q       <= '0;
      cmd_q       <= '0;
      feat_q      <= '0;
      lba_q       <= '0;
      cnt_q       <= '0;
      dev_q       <= '0;
      skip_q      <= 1'b0;
      sh_status_q <= '0;
      sh_error_q  <= '0;
      status_q    <= '0;
      error_q     <= '0;
      err_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      feat_q      <= feat_d;
      lba_q       <= lba_d;
      cnt_q       <= cnt_d;
      dev_q       <= dev_d;
      skip_q      <= skip_d;
      sh_status_q <= sh_status_d;
      sh_error_q  <= sh_error_d;
      status_q    <= status_d;
      error_q     <= error_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    o_cmd_ready = (state_q == IDLE);
    o_busy      = (state_q != IDLE);
    o_done      = (state_q == DONE);
    m_valid     = (state_q == SEND);
    m_last      = (state_q == SEND) && (idx_q == 3'd4);
    m_data      = 32'h0;
    if (state_q == SEND) begin
      case (idx_q)
        3'd0:    m_data = {8'h27, 8'h80, cmd_q, feat_q[7:0]};
        3'd1:    m_data = {dev_q, lba_q[23:0]};
        3'd2:    m_data = {feat_q[15:8], lba_q[47:24]};
        3'd3:    m_data = {16'h0000, cnt_q};
        default: m_data = 32'h0;
      endcase
    end
    o_status  = status_q;
    o_error   = error_q;
    o_err     = err_q;
    o_timeout = tmo_q;
  end
endmodule

// File: tb/tb_sata_cmd_issue.sv
// Table-driven bench for sata_cmd_issue with TX and D2H-result scoreboards.
`timescale 1ns/1ps
module tb_sata_cmd_issue;
  logic        i_tx_clk = 1'b0, i_reset = 1'b1, i_cmd_valid = 1'b0, o_cmd_ready;
  logic [7:0]  i_command = '0, i_device = '0;
  logic [15:0] i_features = '0, i_count = '0;
  logic [47:0] i_lba = '0;
  logic        m_valid, m_ready = 1'b1, m_last;
  logic [31:0] m_data;
  logic        s_valid = 1'b0, s_last = 1'b0, s_abort = 1'b0;
  logic [31:0] s_data = '0;
  logic        o_busy, o_done, o_err, o_timeout;
  logic [7:0]  o_status, o_error;

  sata_cmd_issue #(.TIMEOUT_CYCLES(16)) dut (
    .i_tx_clk(i_tx_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_command(i_command), .i_features(i_features), .i_lba(i_lba), .i_count(i_count),
    .i_device(i_device), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_abort(s_abort), .o_busy(o_busy),
    .o_done(o_done), .o_status(o_status), .o_error(o_error), .o_err(o_err), .o_timeout(o_timeout));

  always #5 i_tx_clk = ~i_tx_clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] feat;
    logic [47:0] lba;
    logic [15:0] cnt;
    logic [7:0]  dev;
    bit          mode;
    int          nrx;
    logic [31:0] rx_d [8];
    logic [7:0]  rx_l;
    logic [7:0]  rx_a;
    logic [7:0]  st;
    logic [7:0]  er;
    logic        e;
  } vec_t;

  vec_t        tbl [5];
  logic [32:0] tx_q [$];
  logic [17:0] rx_q [$];
  int          passed = 0, total = 0, done_cnt = 0;
  bit          rdy_mode = 1'b0, tx_chk_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // m_ready source: always high, or the repeating 1-0-0-1 pattern.
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    forever begin
      @(posedge i_tx_clk); #1;
      m_ready = rdy_mode ? pat[k % 4] : 1'b1;
      k++;
    end
  end

  logic        hold_p = 1'b0;
  logic [32:0] word_p = '0;
  always @(negedge i_tx_clk) begin
    if (tx_chk_en) begin
      if (!m_valid) chk("m_data_idle", m_data, 32'h0);
      if (hold_p) chk("tx_hold", {m_valid, m_last, m_data}, {1'b1, word_p});
      if (m_valid && m_ready) begin
        chk("tx_expected", tx_q.size() > 0, 1);
        if (tx_q.size() > 0) chk("tx_word", {m_last, m_data}, tx_q.pop_front());
      end
    end
    hold_p = m_valid && !m_ready;
    word_p = {m_last, m_data};
  end

  always @(negedge i_tx_clk) begin
    if (o_done) begin
      done_cnt++;
      chk("done_expected", rx_q.size() > 0, 1);
      if (rx_q.size() > 0) chk("d2h_result", {o_status, o_error, o_err, o_timeout}, rx_q.pop_front());
    end
  end

  task automatic issue(input logic [7:0] c, input logic [15:0] f, input logic [47:0] l,
                       input logic [15:0] n, input logic [7:0] d);
    int t;
    tx_q.push_back({1'b0, 8'h27, 8'h80, c, f[7:0]});
    tx_q.push_back({1'b0, d, l[23:0]});
    tx_q.push_back({1'b0, f[15:8], l[47:24]});
    tx_q.push_back({1'b0, 16'h0000, n});
    tx_q.push_back({1'b1, 32'h0});
    i_command = c; i_features = f; i_lba = l; i_count = n; i_device = d;
    i_cmd_valid = 1'b1;
    @(posedge i_tx_clk); #1;
    i_cmd_valid = 1'b0;
    chk("m_valid_lat", m_valid, 1);
    for (t = 0; t < 100; t++) begin
      @(negedge i_tx_clk);
      if (m_valid && m_ready && m_last) break;
    end
    chk("send_bounded", t < 100, 1);
    @(posedge i_tx_clk); #1;
    chk("tx_drained", tx_q.size(), 0);
    chk("wait_state", {o_busy, m_valid, o_cmd_ready}, 3'b100);
  endtask

  initial begin
    int base;
    tbl[0] = '{cmd:8'hC8, feat:16'h0000, lba:48'h0000_0012_3456, cnt:16'h0004, dev:8'h40, mode:1'b0, nrx:4,
               rx_d:'{32'h34005000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
               rx_l:8'b0000_1000, rx_a:8'h00, st:8'h50, er:8'h00, e:1'b0};
    tbl[1] = '{cmd:8'h25, feat:16'hAB01, lba:48'hA1B2_C3D4_E5F6, cnt:16'h1234, dev:8'hE0, mode:1'b1, nrx:6,
               rx_d:'{32'h46000000, 32'h34AAAAAA, 32'h2, 32'h3, 32'h4, 32'h34005104, 32'h0, 32'h0},
               rx_l:8'b0011_0000, rx_a:8'h00, st:8'h51, er:8'h04, e:1'b1};
    tbl[2] = '{cmd:8'h35, feat:16'h0000, lba:48'h0000_0000_0100, cnt:16'h0001, dev:8'h40, mode:1'b0, nrx:8,
               rx_d:'{32'h34008000, 32'h0, 32'h0, 32'h0, 32'h34005000, 32'h0, 32'h0, 32'h0},
               rx_l:8'b1000_1000, rx_a:8'h00, st:8'h50, er:8'h00, e:1'b0};
    tbl[3] = '{cmd:8'hC8, feat:16'h0000, lba:48'h0000_0000_0200, cnt:16'h0008, dev:8'h40, mode:1'b0, nrx:4,
               rx_d:'{32'h34005000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
               rx_l:8'b0000_1000, rx_a:8'b0000_1000, st:8'h50, er:8'h00, e:1'b1};
    tbl[4] = '{cmd:8'hEC, feat:16'h0000, lba:48'h0, cnt:16'h0000, dev:8'hA0, mode:1'b1, nrx:1,
               rx_d:'{32'h34004100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
               rx_l:8'b0000_0001, rx_a:8'h00, st:8'h41, er:8'h00, e:1'b1};

    repeat (3) @(posedge i_tx_clk);
    #1;
    chk("rst_tx", {m_valid, m_last, m_data}, 34'h0);
    chk("rst_ctl", {o_done, o_busy, o_cmd_ready}, 3'b001);
    chk("rst_result", {o_status, o_error, o_err, o_timeout}, 18'h0);
    i_reset = 1'b0;
    @(posedge i_tx_clk); #1;
    chk("idle_ready", {o_cmd_ready, o_busy, m_valid}, 3'b100);

    for (int r = 0; r < 5; r++) begin
      rdy_mode = tbl[r].mode;
      issue(tbl[r].cmd, tbl[r].feat, tbl[r].lba, tbl[r].cnt, tbl[r].dev);
      rdy_mode = 1'b0;
      rx_q.push_back({tbl[r].st, tbl[r].er, tbl[r].e, 1'b0});
      for (int i = 0; i < tbl[r].nrx; i++) begin
        s_valid = 1'b1; s_data = tbl[r].rx_d[i]; s_last = tbl[r].rx_l[i]; s_abort = tbl[r].rx_a[i];
        @(posedge i_tx_clk); #1;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_abort = 1'b0;
        if (tbl[r].rx_l[i]) chk("done_lat", o_done, i == tbl[r].nrx - 1);
      end
      @(posedge i_tx_clk); #1;
      chk("idle_after", {o_busy, o_done}, 2'b00);
    end

    // Reset in the middle of SEND: link stops, no completion.
    base = done_cnt;
    tx_chk_en = 1'b0;
    i_command = 8'hC8; i_cmd_valid = 1'b1;
    @(posedge i_tx_clk); #1;
    i_cmd_valid = 1'b0;
    @(posedge i_tx_clk); #1;
    chk("send_active", m_valid, 1);
    i_reset = 1'b1;
    @(posedge i_tx_clk); #1;
    chk("rst_mid_send", {m_valid, o_busy, o_cmd_ready}, 3'b001);
    i_reset = 1'b0;
    repeat (8) @(posedge i_tx_clk);
    #1;
    chk("rst_no_done", done_cnt, base);
    tx_chk_en = 1'b1;

    // New request while waiting is not queued.
    issue(8'h60, 16'h0010, 48'h0000_0000_1000, 16'h0010, 8'h40);
    i_cmd_valid = 1'b1;
    repeat (3) begin
      @(posedge i_tx_clk); #1;
      chk("busy_ignore", {o_cmd_ready, m_valid}, 2'b00);
    end
    i_cmd_valid = 1'b0;
    rx_q.push_back({8'h50, 8'h00, 1'b0, 1'b0});
    s_valid = 1'b1; s_data = 32'h34005000; s_last = 1'b1;
    @(posedge i_tx_clk); #1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    chk("done_lat", o_done, 1);
    repeat (4) begin
      @(posedge i_tx_clk); #1;
      chk("no_queued_cmd", {m_valid, o_busy}, 2'b00);
    end

`ifdef SATACMD_TIMEOUT_EN
    begin
      int t;
      issue(8'hC8, 16'h0, 48'h0, 16'h1, 8'h40);
      rx_q.push_back({8'hFF, 8'h00, 1'b1, 1'b1});
      for (t = 1; t <= 40; t++) begin
        @(posedge i_tx_clk); #1;
        if (o_done) break;
      end
      chk("tmo_lat", t, 16);
      @(posedge i_tx_clk); #1;
    end
`endif

    chk("tx_q_empty", tx_q.size(), 0);
    chk("rx_q_empty", rx_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
